// File: rtl/wb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} wb_arb_state_t;

   localparam int WB_ARB_NMASTERS = 2;

   // Grant state for a master index (0 -> GNT0, 1 -> GNT1)
   function automatic wb_arb_state_t wb_arb_gnt_state(input logic i_m1);
      return i_m1 ? ARB_GNT1 : ARB_GNT0;
   endfunction

endpackage

// File: rtl/wb_arb_outst_ctr.sv
// Saturating up/down counter of in-flight slave beats. Clear wins over inc/dec;
// simultaneous inc and dec leave the count unchanged.
module wb_arb_outst_ctr #(
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               i_inc,
   input  logic                               i_dec,
   input  logic                               i_clr,
   output logic [$clog2(MAX_OUTST+1)-1:0]     o_cnt,
   output logic                               o_full,
   output logic                               o_empty
);

   localparam int unsigned CW = $clog2(MAX_OUTST + 1);
   localparam logic [CW-1:0] MaxVal = CW'(MAX_OUTST);

   logic [CW-1:0] r_cnt;

   // Count state: saturates at both ends, never wraps
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !i_dec && !o_full) begin
         r_cnt <= r_cnt + CW'(1);
      end else if (i_dec && !i_inc && !o_empty) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_cnt   = r_cnt;
   assign o_full  = (r_cnt == MaxVal);
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave Wishbone B4 pipelined arbiter. Grants whole cyc spans and
// counts in-flight beats so a handover never routes a stale ack to the new owner.
// Optional: define WB_ARB_RR_EN for round-robin tie-break (default: m0 wins ties).
module wb_arbiter_2m
   import wb_pkg::*;
#(
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_m0_cyc,
   input  logic            i_m0_stb,
   input  logic            i_m0_we,
   input  logic [AW-1:0]   i_m0_adr,
   input  logic [DW-1:0]   i_m0_dat_w,
   input  logic [DW/8-1:0] i_m0_sel,
   output logic            o_m0_ack,
   output logic            o_m0_err,
   output logic            o_m0_stall,
   input  logic            i_m1_cyc,
   input  logic            i_m1_stb,
   input  logic            i_m1_we,
   input  logic [AW-1:0]   i_m1_adr,
   input  logic [DW-1:0]   i_m1_dat_w,
   input  logic [DW/8-1:0] i_m1_sel,
   output logic            o_m1_ack,
   output logic            o_m1_err,
   output logic            o_m1_stall,
   output logic [DW-1:0]   o_m_dat_r,
   output logic            o_s_cyc,
   output logic            o_s_stb,
   output logic            o_s_we,
   output logic [AW-1:0]   o_s_adr,
   output logic [DW-1:0]   o_s_dat_w,
   output logic [DW/8-1:0] o_s_sel,
   input  logic            i_s_ack,
   input  logic            i_s_err,
   input  logic            i_s_stall,
   input  logic [DW-1:0]   i_s_dat_r
);

   localparam int unsigned CW = $clog2(MAX_OUTST + 1);

   wb_arb_state_t r_state;
   logic [CW-1:0] w_outst;
   logic          w_full;
   logic          w_empty;
   logic          w_cyc_sel;
   logic          w_inc;
   logic          w_dec;
   logic          w_clr;
   logic          w_tie_m1;

   assign w_cyc_sel = (r_state == ARB_GNT0) ? i_m0_cyc :
                      (r_state == ARB_GNT1) ? i_m1_cyc : 1'b0;
   assign w_inc     = o_s_stb & ~i_s_stall;
   // Responses with nothing in flight are slave protocol errors and must not count
   assign w_dec     = (i_s_ack | i_s_err) & w_cyc_sel & ~w_empty;
   // Owner dropping cyc aborts its cycle: late responses are forgotten
   assign w_clr     = ~w_cyc_sel;

`ifdef WB_ARB_RR_EN
   logic r_last_gnt;

   assign w_tie_m1 = ~r_last_gnt;

   // Remember which master held the bus most recently (m1 at reset so m0 wins first tie)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last_gnt <= 1'b1;
      end else if (r_state == ARB_GNT0) begin
         r_last_gnt <= 1'b0;
      end else if (r_state == ARB_GNT1) begin
         r_last_gnt <= 1'b1;
      end
   end
`else
   assign w_tie_m1 = 1'b0;
`endif

   // Grant FSM: ownership changes only at cyc boundaries, handover without an idle bubble
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ARB_IDLE;
      end else begin
         unique case (r_state)
            ARB_IDLE: begin
               if (i_m0_cyc && i_m1_cyc) r_state <= wb_arb_gnt_state(w_tie_m1);
               else if (i_m0_cyc)        r_state <= ARB_GNT0;
               else if (i_m1_cyc)        r_state <= ARB_GNT1;
            end
            ARB_GNT0: if (!i_m0_cyc) r_state <= i_m1_cyc ? ARB_GNT1 : ARB_IDLE;
            ARB_GNT1: if (!i_m1_cyc) r_state <= i_m0_cyc ? ARB_GNT0 : ARB_IDLE;
            default:  r_state <= ARB_IDLE;
         endcase
      end
   end

   // Slave-side mux and per-master responses, decoded from the registered grant
   always_comb begin
      o_s_cyc    = 1'b0;
      o_s_stb    = 1'b0;
      o_s_we     = 1'b0;
      o_s_adr    = i_m0_adr;
      o_s_dat_w  = i_m0_dat_w;
      o_s_sel    = i_m0_sel;
      o_m0_stall = 1'b1;
      o_m1_stall = 1'b1;
      o_m0_ack   = 1'b0;
      o_m0_err   = 1'b0;
      o_m1_ack   = 1'b0;
      o_m1_err   = 1'b0;
      unique case (r_state)
         ARB_GNT0: begin
            o_s_cyc    = i_m0_cyc;
            o_s_stb    = i_m0_cyc & i_m0_stb & ~w_full;
            o_s_we     = i_m0_we;
            o_m0_stall = i_s_stall | w_full;
            o_m0_ack   = i_m0_cyc & i_s_ack & ~w_empty;
            o_m0_err   = i_m0_cyc & i_s_err & ~w_empty;
         end
         ARB_GNT1: begin
            o_s_cyc    = i_m1_cyc;
            o_s_stb    = i_m1_cyc & i_m1_stb & ~w_full;
            o_s_we     = i_m1_we;
            o_s_adr    = i_m1_adr;
            o_s_dat_w  = i_m1_dat_w;
            o_s_sel    = i_m1_sel;
            o_m1_stall = i_s_stall | w_full;
            o_m1_ack   = i_m1_cyc & i_s_ack & ~w_empty;
            o_m1_err   = i_m1_cyc & i_s_err & ~w_empty;
         end
         default: ;
      endcase
   end

   assign o_m_dat_r = i_s_dat_r;

   wb_arb_outst_ctr #(
      .MAX_OUTST (MAX_OUTST)
   ) u_ctr (
      .clk     (clk),
      .rstn    (rstn),
      .i_inc   (w_inc),
      .i_dec   (w_dec),
      .i_clr   (w_clr),
      .o_cnt   (w_outst),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: table of arbitration cases, a behavioural slave with
// configurable ack delay / error address / stall, and a per-master response scoreboard.
module tb_wb_arbiter_2m;
   import wb_pkg::*;

   localparam int unsigned MAXO = 4;
   localparam logic [31:0] KEY  = 32'hA5A5_5A5A;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        m0_cyc = 0, m0_stb = 0, m1_cyc = 0, m1_stb = 0;
   logic        m0_we = 0, m1_we = 0;
   logic [31:0] m0_adr = '0, m1_adr = '0, m0_dat_w = '0, m1_dat_w = '0;
   logic [3:0]  m0_sel = 4'hF, m1_sel = 4'hF;
   logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
   logic [31:0] m_dat_r;
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr, s_dat_w;
   logic [3:0]  s_sel;
   logic        s_ack = 0, s_err = 0, s_stall = 0;
   logic [31:0] s_dat_r = '0;

   always #5 clk = ~clk;

   wb_arbiter_2m #(.AW(32), .DW(32), .MAX_OUTST(MAXO)) dut (
      .clk(clk), .rstn(rstn),
      .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_adr(m0_adr),
      .i_m0_dat_w(m0_dat_w), .i_m0_sel(m0_sel),
      .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_stall(m0_stall),
      .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_adr(m1_adr),
      .i_m1_dat_w(m1_dat_w), .i_m1_sel(m1_sel),
      .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_stall(m1_stall),
      .o_m_dat_r(m_dat_r),
      .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
      .o_s_dat_w(s_dat_w), .o_s_sel(s_sel),
      .i_s_ack(s_ack), .i_s_err(s_err), .i_s_stall(s_stall), .i_s_dat_r(s_dat_r)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural slave ----------------
   typedef struct {int due; logic [31:0] adr;} beat_t;
   beat_t       sq[$];
   int          ack_delay = 1;
   logic [31:0] err_adr   = 32'hFFFF_FFFF;
   logic        stall_req = 1'b0;
   int          cyc_n     = 0;

   always begin : slave
      logic        acc, acked;
      logic [31:0] a;
      @(negedge clk);
      acc   = s_cyc & s_stb & ~s_stall;
      acked = s_ack | s_err;
      a     = s_adr;
      @(posedge clk);
      cyc_n++;
      if (!rstn) begin
         sq.delete();
      end else begin
         if (acked && sq.size() > 0) void'(sq.pop_front());
         if (acc) sq.push_back('{cyc_n + ack_delay, a});
      end
      #1;
      s_stall = stall_req;
      s_ack   = 1'b0;
      s_err   = 1'b0;
      s_dat_r = '0;
      if (rstn && sq.size() > 0 && sq[0].due <= cyc_n) begin
         if (sq[0].adr == err_adr) s_err = 1'b1;
         else                      s_ack = 1'b1;
         s_dat_r = sq[0].adr ^ KEY;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct {logic [31:0] dat; logic err;} exp_t;
   exp_t q0[$], q1[$];
   int   ack_cnt[2];
   int   err_cnt[2];
   int   max_outst = 0;
   bit   saw_full_stall = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         if (m0_cyc && m0_stb && !m0_stall) q0.push_back('{m0_adr ^ KEY, m0_adr == err_adr});
         if (m1_cyc && m1_stb && !m1_stall) q1.push_back('{m1_adr ^ KEY, m1_adr == err_adr});
         if (m0_ack || m0_err) begin
            if (q0.size() == 0) check("m0 unexpected response", 32'(m0_ack | m0_err), 32'd0);
            else begin
               e = q0.pop_front();
               check("m0 err flag", 32'(m0_err), 32'(e.err));
               if (m0_ack) check("m0 read data", m_dat_r, e.dat);
            end
            if (m0_ack) ack_cnt[0]++;
            if (m0_err) err_cnt[0]++;
         end
         if (m1_ack || m1_err) begin
            if (q1.size() == 0) check("m1 unexpected response", 32'(m1_ack | m1_err), 32'd0);
            else begin
               e = q1.pop_front();
               check("m1 err flag", 32'(m1_err), 32'(e.err));
               if (m1_ack) check("m1 read data", m_dat_r, e.dat);
            end
            if (m1_ack) ack_cnt[1]++;
            if (m1_err) err_cnt[1]++;
         end
         if (int'(dut.w_outst) > max_outst) max_outst = int'(dut.w_outst);
         if (int'(dut.w_outst) == MAXO && dut.r_state == ARB_GNT1 && m1_stall)
            saw_full_stall = 1;
      end
   end

   // ---------------- master drivers ----------------
   task automatic drv(input int m, input logic cyc, input logic stb, input logic [31:0] adr);
      if (m == 0) begin
         m0_cyc = cyc; m0_stb = stb; m0_adr = adr; m0_dat_w = ~adr;
      end else begin
         m1_cyc = cyc; m1_stb = stb; m1_adr = adr; m1_dat_w = ~adr;
      end
   endtask

   // Pipelined burst of n beats; waits for all responses, optionally keeps cyc high
   task automatic run_burst(input int m, input int n, input logic [31:0] adr0, input bit hold);
      int   i, g, target;
      logic acc;
      i = 0;
      g = 0;
      target = ack_cnt[m] + err_cnt[m] + n;
      @(posedge clk); #1;
      drv(m, 1'b1, 1'b1, adr0);
      while (i < n && g < 200) begin
         @(negedge clk);
         acc = (m == 0) ? ~m0_stall : ~m1_stall;
         @(posedge clk); #1;
         if (acc) i++;
         drv(m, 1'b1, (i < n), adr0 + 32'(4 * ((i < n) ? i : n - 1)));
         g++;
      end
      check($sformatf("m%0d beats issued", m), 32'(i), 32'(n));
      g = 0;
      while (ack_cnt[m] + err_cnt[m] < target && g < 200) begin
         @(negedge clk);
         g++;
      end
      check($sformatf("m%0d responses", m), 32'(ack_cnt[m] + err_cnt[m]), 32'(target));
      if (!hold) begin
         @(posedge clk); #1;
         drv(m, 1'b0, 1'b0, adr0);
      end
   endtask

   // ---------------- arbitration table ----------------
   typedef struct {
      logic          m0c;
      logic          m1c;
      wb_arb_state_t exp_fix;
      wb_arb_state_t exp_rr;
   } arb_vec_t;
   arb_vec_t vt[5];

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      wb_arb_state_t exp_st;
      int            a0, a1, e0;

      vt[0] = '{1'b1, 1'b0, ARB_GNT0, ARB_GNT0};
      vt[1] = '{1'b0, 1'b1, ARB_GNT1, ARB_GNT1};
      vt[2] = '{1'b1, 1'b1, ARB_GNT0, ARB_GNT0};
      vt[3] = '{1'b1, 1'b1, ARB_GNT0, ARB_GNT1};
      vt[4] = '{1'b0, 1'b0, ARB_IDLE, ARB_IDLE};

      // Reset values
      @(negedge clk);
      check("reset state", 32'(dut.r_state), 32'(ARB_IDLE));
      check("reset outst", 32'(dut.w_outst), 32'd0);
      check("reset s_cyc", 32'(s_cyc), 32'd0);
      check("reset s_stb", 32'(s_stb), 32'd0);
      check("reset m0_stall", 32'(m0_stall), 32'd1);
      check("reset m1_stall", 32'(m1_stall), 32'd1);
      check("reset acks", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
      @(posedge clk); #1 rstn = 1'b1;
      repeat (2) @(posedge clk);

      // Arbitration table (tie-break order depends on build)
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         m0_cyc = vt[k].m0c;
         m1_cyc = vt[k].m1c;
`ifdef WB_ARB_RR_EN
         exp_st = vt[k].exp_rr;
`else
         exp_st = vt[k].exp_fix;
`endif
         @(negedge clk);
         check($sformatf("vec%0d s_cyc before grant", k), 32'(s_cyc), 32'd0);
         @(negedge clk);
         check($sformatf("vec%0d grant", k), 32'(dut.r_state), 32'(exp_st));
         check($sformatf("vec%0d s_cyc", k), 32'(s_cyc), 32'(exp_st != ARB_IDLE));
         check($sformatf("vec%0d m0_stall", k), 32'(m0_stall), 32'(exp_st != ARB_GNT0));
         check($sformatf("vec%0d m1_stall", k), 32'(m1_stall), 32'(exp_st != ARB_GNT1));
         @(posedge clk); #1;
         m0_cyc = 1'b0;
         m1_cyc = 1'b0;
         repeat (2) @(posedge clk);
      end

      // Single read from m0, ack one cycle after the strobe
      ack_delay = 1;
      a1 = ack_cnt[1];
      a0 = ack_cnt[0];
      fork
         run_burst(0, 1, 32'h100, 1'b0);
         begin
            @(posedge clk);
            @(negedge clk);
            check("t1 s_cyc lags m0_cyc", 32'(s_cyc), 32'd0);
            @(negedge clk);
            check("t1 s_cyc after grant", 32'(s_cyc), 32'd1);
            check("t1 s_adr", s_adr, 32'h100);
         end
      join
      @(negedge clk);
      @(negedge clk);
      check("t1 back to idle", 32'(dut.r_state), 32'(ARB_IDLE));
      check("t1 m0 ack count", 32'(ack_cnt[0] - a0), 32'd1);
      check("t1 m1 ack count", 32'(ack_cnt[1] - a1), 32'd0);

      // Slave stall holds the owner off without counting a beat
      stall_req = 1'b1;
      fork
         run_burst(0, 1, 32'h140, 1'b0);
         begin
            @(posedge clk);
            repeat (3) @(negedge clk);
            check("stall m0_stall", 32'(m0_stall), 32'd1);
            check("stall s_stb", 32'(s_stb), 32'd1);
            check("stall outst", 32'(dut.w_outst), 32'd0);
            stall_req = 1'b0;
         end
      join
      repeat (3) @(posedge clk);

      // m1 six back-to-back beats, ack latency 3: counter must saturate at 4
      ack_delay = 3;
      max_outst = 0;
      saw_full_stall = 0;
      a1 = ack_cnt[1];
      run_burst(1, 6, 32'h200, 1'b0);
      check("t3 max outstanding", 32'(max_outst), 32'(MAXO));
      check("t3 stall when full", 32'(saw_full_stall), 32'd1);
      check("t3 m1 acks", 32'(ack_cnt[1] - a1), 32'd6);
      repeat (3) @(posedge clk);

      // Error on beat 2 of a 3-beat m0 burst; bus stays with m0
      ack_delay = 1;
      err_adr = 32'h304;
      a0 = ack_cnt[0];
      e0 = err_cnt[0];
      run_burst(0, 3, 32'h300, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("t5 m0 err pulses", 32'(err_cnt[0] - e0), 32'd1);
      check("t5 m0 acks", 32'(ack_cnt[0] - a0), 32'd2);
      check("t5 bus held", 32'(dut.r_state), 32'(ARB_GNT0));
      check("t5 outst drained", 32'(dut.w_outst), 32'd0);
      @(posedge clk); #1 drv(0, 1'b0, 1'b0, 32'h0);
      err_adr = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);

      // m0 aborts with 2 beats in flight while m1 waits: handover, late acks dropped
      ack_delay = 3;
      fork
         begin
            @(posedge clk); #1 drv(0, 1'b1, 1'b1, 32'h500);
            @(posedge clk);
            @(posedge clk); #1 drv(0, 1'b1, 1'b1, 32'h504);
            @(posedge clk); #1 drv(0, 1'b1, 1'b0, 32'h504);
            @(posedge clk);
            @(posedge clk); #1 drv(0, 1'b0, 1'b0, 32'h504);
            @(negedge clk);
            check("t4 exit cycle still GNT0", 32'(dut.r_state), 32'(ARB_GNT0));
            check("t4 late ack not to m0", 32'(m0_ack | m0_err), 32'd0);
            @(negedge clk);
            check("t4 handover to GNT1", 32'(dut.r_state), 32'(ARB_GNT1));
            check("t4 late ack not to m1", 32'(m1_ack | m1_err), 32'd0);
         end
         begin
            @(posedge clk);
            @(posedge clk);
            run_burst(1, 2, 32'h600, 1'b0);
         end
      join
      check("t4 m0 beats left unanswered", 32'(q0.size()), 32'd2);
      q0.delete();
      repeat (3) @(posedge clk);

      // Reset in the middle of an m1 burst
      ack_delay = 6;
      @(posedge clk); #1 drv(1, 1'b1, 1'b1, 32'h700);
      repeat (4) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("t6 s_cyc in reset", 32'(s_cyc), 32'd0);
      check("t6 s_stb in reset", 32'(s_stb), 32'd0);
      check("t6 stalls in reset", 32'({m0_stall, m1_stall}), 32'd3);
      check("t6 state in reset", 32'(dut.r_state), 32'(ARB_IDLE));
      check("t6 outst in reset", 32'(dut.w_outst), 32'd0);
      drv(1, 1'b0, 1'b0, 32'h0);
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      ack_delay = 1;
      run_burst(1, 1, 32'h800, 1'b0);
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
